// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: FSM state codes, frame shape and baud divider math.
// Also used by the transmitter, so keep it free of receiver-only details.
package rs232_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Integer division: the residual baud error is absorbed by mid-bit sampling.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned calc_half(input int unsigned clk_hz, input int unsigned baud);
    return calc_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for an asynchronous input pin; reset value selects the
// pin's idle level so no spurious edge is seen when reset is released.
module rs232_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232_rx.sv
// 8N1 UART receiver: mid-bit sampling from a half-bit start qualification,
// one-cycle valid / frame_err strobes, break hold-off after a bad stop bit.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned HALF = calc_half(CLK_HZ, BAUD);
  localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  rs232_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  // busy is derived from the state register, so it drops in the strobe cycle.
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_M1;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              cnt   <= DIV_M1;
              idx   <= '0;
              state <= DATA;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            sh  <= {rxs, sh[7:1]};
            cnt <= DIV_M1;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rxs) begin
              data  <= sh;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx: host line model drives frames, a scoreboard of
// expected strobes is popped whenever the receiver reports a byte or framing error.
module tb_rs232_rx;

  localparam int unsigned DIVB = 434;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  longint      cyc;
  longint      valid_cyc;
  logic [7:0]  last_good;
  logic        prev_valid;
  logic        prev_fe;

  rs232_rx #(.CLK_HZ(50_000_000), .BAUD(115200)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_good(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.d      = b;
    exp_q.push_back(e);
    last_good = b;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.d      = last_good;
    exp_q.push_back(e);
  endtask

  // abort_bit >= 0 pulses reset in the middle of that data bit and ends the frame.
  task automatic send_byte(input logic [7:0] b, input int bit_clks, input logic stop_val,
                           input int abort_bit);
    rxd = 1'b0;
    tick(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == abort_bit) begin
        tick(bit_clks / 2);
        rst_n = 1'b0;
        tick(3);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rxd = 1'b1;
        tick(2);
        rst_n = 1'b1;
        last_good = 8'h00;
        tick(10);
        return;
      end
      tick(bit_clks);
    end
    rxd = stop_val;
    tick(bit_clks);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      exp_t it;
      check("strobe_excl", valid & frame_err, 1'b0);
      check("strobe_width", (valid & prev_valid) | (frame_err & prev_fe), 1'b0);
      if (exp_q.size() == 0) begin
        check("strobe_expected", 32'(exp_q.size() != 0), 1);
      end else begin
        it = exp_q.pop_front();
        check("strobe_kind", frame_err, it.is_err);
        check("strobe_data", data, it.d);
        check("strobe_busy", busy, it.is_err);
      end
      if (valid) valid_cyc = cyc;
    end
    prev_valid = valid;
    prev_fe    = frame_err;
  end

  initial begin
    longint t_start;
    checks     = 0;
    failures   = 0;
    last_good  = 8'h00;
    prev_valid = 1'b0;
    prev_fe    = 1'b0;
    valid_cyc  = 0;
    rst_n      = 1'b0;
    rxd        = 1'b1;
    tick(5);
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick(20);

    // Single byte with latency measurement.
    push_good(8'h55);
    t_start = cyc;
    send_byte(8'h55, DIVB, 1'b1, -1);
    wait_drain("drain_55", 1000);
    check("latency_55", 32'((valid_cyc - t_start) inside {[4125:4127]}), 1);
    tick(100);

    // Back-to-back frames, one stop bit, no idle gap.
    push_good(8'h00);
    send_byte(8'h00, DIVB, 1'b1, -1);
    push_good(8'hFF);
    send_byte(8'hFF, DIVB, 1'b1, -1);
    push_good(8'hA5);
    send_byte(8'hA5, DIVB, 1'b1, -1);
    wait_drain("drain_b2b", 1000);
    tick(100);

    // Framing error followed by a held-low break.
    push_err();
    send_byte(8'h3C, DIVB, 1'b0, -1);
    tick(20 * DIVB);
    check("break_busy", busy, 1'b1);
    wait_drain("drain_ferr", 10);
    rxd = 1'b1;
    tick(2 * DIVB);
    check("break_exit_busy", busy, 1'b0);
    push_good(8'h81);
    send_byte(8'h81, DIVB, 1'b1, -1);
    wait_drain("drain_81", 1000);
    tick(100);

    // Short low glitch on an idle line.
    rxd = 1'b0;
    tick(50);
    rxd = 1'b1;
    tick(169);
    check("glitch_busy_hi", busy, 1'b1);
    tick(1);
    check("glitch_busy_lo", busy, 1'b0);
    tick(DIVB);

    // Reset mid-frame, then a clean frame.
    send_byte(8'hC3, DIVB, 1'b1, 4);
    check("post_rst_data", data, 8'h00);
    push_good(8'h42);
    send_byte(8'h42, DIVB, 1'b1, -1);
    wait_drain("drain_42", 1000);
    tick(100);

    // Host baud skew of +3% and -3%.
    push_good(8'h96);
    send_byte(8'h96, 447, 1'b1, -1);
    wait_drain("drain_skew_slow", 1000);
    tick(100);
    push_good(8'h96);
    send_byte(8'h96, 421, 1'b1, -1);
    wait_drain("drain_skew_fast", 1000);
    tick(DIVB);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_data", data, 8'h96);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
